// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the integer register file.
package cpu_pkg;

    localparam int DATA_W     = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int ZERO_REG   = 31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     word_t;

endpackage

// File: rtl/regfile_dec5_32.sv
// 5-to-32 one-hot write-enable decoder; the hardwired-zero register never gets an enable.
module regfile_dec5_32
    import cpu_pkg::*;
#(
    parameter int ZERO_REG = cpu_pkg::ZERO_REG
) (
    input  logic                i_we,
    input  reg_addr_t           i_addr,
    output logic [NUM_REGS-1:0] o_we
);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        o_we = '0;
        if (i_we) begin
            o_we[i_addr] = 1'b1;
        end
        o_we[ZERO_REG] = 1'b0;
    end

endmodule

// File: rtl/regfile.sv
// 32-entry, two-read/one-write register file with a hardwired-zero entry.
// Optional same-cycle write-through forwarding when REGFILE_BYPASS_EN is defined.
module regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS,
    parameter int ZERO_REG = cpu_pkg::ZERO_REG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  reg_addr_t         WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  reg_addr_t         ReadRegister1,
    input  reg_addr_t         ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    logic [NUM_REGS-1:0] w_we;
    logic [DATA_W-1:0]   w_regs [NUM_REGS];
    logic [DATA_W-1:0]   w_rd1;
    logic [DATA_W-1:0]   w_rd2;

    regfile_dec5_32 #(
        .ZERO_REG (ZERO_REG)
    ) u_dec (
        .i_we   (RegWrite),
        .i_addr (WriteRegister),
        .o_we   (w_we)
    );

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            assign w_regs[i] = '0;
        end else begin : g_store
            logic [DATA_W-1:0] r_q;

            // NOTE: the storage is a bank of flops, so each entry is cleared by reset; reset outranks the write enable.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_q <= '0;
                end else if (w_we[i]) begin
                    r_q <= WriteData;
                end
            end

            assign w_regs[i] = r_q;
        end
    end

    // Binary 2:1 tree, one level per select bit, collapsing 32 entries to one.
    function automatic logic [DATA_W-1:0] mux32(
        input reg_addr_t         sel,
        input logic [DATA_W-1:0] regs [NUM_REGS]
    );
        logic [DATA_W-1:0] lvl [NUM_REGS];
        for (int k = 0; k < NUM_REGS; k++) lvl[k] = regs[k];
        for (int l = 0; l < REG_ADDR_W; l++) begin
            for (int k = 0; k < (NUM_REGS >> (l + 1)); k++) begin
                lvl[k] = sel[l] ? lvl[2*k+1] : lvl[2*k];
            end
        end
        return lvl[0];
    endfunction

    assign w_rd1 = mux32(ReadRegister1, w_regs);
    assign w_rd2 = mux32(ReadRegister2, w_regs);

`ifdef REGFILE_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;
    logic w_wr_live;

    // Forward only writes that will really land: not during reset, never to the zero entry.
    assign w_wr_live = RegWrite && !reset && (WriteRegister != REG_ADDR_W'(ZERO_REG));
    assign w_fwd1    = w_wr_live && (WriteRegister == ReadRegister1);
    assign w_fwd2    = w_wr_live && (WriteRegister == ReadRegister2);

    assign ReadData1 = w_fwd1 ? WriteData : w_rd1;
    assign ReadData2 = w_fwd2 ? WriteData : w_rd2;
`else
    assign ReadData1 = w_rd1;
    assign ReadData2 = w_rd2;
`endif

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile;
    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    reg_addr_t   WriteRegister;
    logic [63:0] WriteData;
    reg_addr_t   ReadRegister1;
    reg_addr_t   ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int checks = 0;
    int errors = 0;

    regfile dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int addr, input logic [63:0] data);
        RegWrite      = 1'b1;
        WriteRegister = reg_addr_t'(addr);
        WriteData     = data;
        tick();
        RegWrite      = 1'b0;
    endtask

    task automatic read_pair(input int a1, input int a2);
        ReadRegister1 = reg_addr_t'(a1);
        ReadRegister2 = reg_addr_t'(a2);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        tick();
        reset = 1'b0;

        // Every address reads zero on both ports after reset.
        for (int a = 0; a < 32; a++) begin
            read_pair(a, 31 - a);
            check($sformatf("rst_p1_x%0d", a), ReadData1, 64'h0);
            check($sformatf("rst_p2_x%0d", 31 - a), ReadData2, 64'h0);
        end

        // Plain write, then read on both ports; neighbours untouched.
        do_write(5, 64'hDEAD_BEEF_0123_4567);
        read_pair(5, 5);
        check("x5_p1", ReadData1, 64'hDEAD_BEEF_0123_4567);
        check("x5_p2", ReadData2, 64'hDEAD_BEEF_0123_4567);
        read_pair(4, 6);
        check("x4_p1", ReadData1, 64'h0);
        check("x6_p2", ReadData2, 64'h0);

        // Write to the zero register reads zero in the same and the next cycle.
        RegWrite      = 1'b1;
        WriteRegister = 5'd31;
        WriteData     = 64'hFFFF_FFFF_FFFF_FFFF;
        read_pair(31, 31);
        check("x31_same_p1", ReadData1, 64'h0);
        check("x31_same_p2", ReadData2, 64'h0);
        tick();
        RegWrite = 1'b0;
        read_pair(31, 5);
        check("x31_next_p1", ReadData1, 64'h0);
        check("x5_after_x31", ReadData2, 64'hDEAD_BEEF_0123_4567);
        read_pair(30, 0);
        check("x30_after_x31", ReadData1, 64'h0);
        check("x0_after_x31", ReadData2, 64'h0);

        // Same-cycle write and read of one address.
        do_write(7, 64'h11);
        RegWrite      = 1'b1;
        WriteRegister = 5'd7;
        WriteData     = 64'h55;
        read_pair(7, 8);
`ifdef REGFILE_BYPASS_EN
        check("x7_same_cycle", ReadData1, 64'h55);
`else
        check("x7_same_cycle", ReadData1, 64'h11);
`endif
        check("x8_other_port", ReadData2, 64'h0);
        tick();
        RegWrite = 1'b0;
        read_pair(7, 7);
        check("x7_next_p1", ReadData1, 64'h55);
        check("x7_next_p2", ReadData2, 64'h55);

        // Disabled write leaves the addressed register alone.
        do_write(9, 64'h999);
        RegWrite      = 1'b0;
        WriteRegister = 5'd9;
        WriteData     = 64'h123;
        read_pair(9, 9);
        check("x9_we0_same", ReadData1, 64'h999);
        tick();
        read_pair(9, 9);
        check("x9_we0_next", ReadData2, 64'h999);

        // Fill X0..X30 with their index, then reset with a write pending.
        for (int a = 0; a < 31; a++) do_write(a, 64'(a));
        read_pair(3, 30);
        check("fill_x3", ReadData1, 64'd3);
        check("fill_x30", ReadData2, 64'd30);
        read_pair(0, 17);
        check("fill_x0", ReadData1, 64'd0);
        check("fill_x17", ReadData2, 64'd17);

        reset         = 1'b1;
        RegWrite      = 1'b1;
        WriteRegister = 5'd3;
        WriteData     = 64'hAA;
        read_pair(3, 3);
        check("x3_during_reset", ReadData1, 64'd3);
        tick();
        reset    = 1'b0;
        RegWrite = 1'b0;
        for (int a = 0; a < 32; a++) begin
            read_pair(a, a);
            check($sformatf("rst2_p1_x%0d", a), ReadData1, 64'h0);
            check($sformatf("rst2_p2_x%0d", a), ReadData2, 64'h0);
        end

        // A write after reset lands normally.
        do_write(3, 64'h0BAD_F00D);
        read_pair(3, 2);
        check("x3_post_reset", ReadData1, 64'h0BAD_F00D);
        check("x2_post_reset", ReadData2, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
